tone_capture_sequencer: RTL

//  Sequences the FFT for one tone-detection recording.
//  - Splits recording_length into N_FRAMES evenly spaced slots and launches one FFT per slot.
//  - Scans each FFT output frame for the peak-magnitude bin.
//  - Hands each peak bin to the tone detector (tone_detection_fsm) over a valid/ready handshake.
//  - Sits between the audio/FFT datapath and the tone detector, and owns the FFT start timing.
//

---
 rtl/tone_capture_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/tone_capture_sequencer.sv
// Tone-capture FFT sequencer: launches one FFT per recording slot, finds the
// peak-magnitude bin of each frame and hands it to the tone detector.
module tone_capture_sequencer #(
  parameter int N_FRAMES = 4,
  parameter int BIN_W    = 10,
  parameter int MAG_W    = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [31:0]      recording_length,
  input  logic             fft_ready_in,
  output logic             fft_start_out,
  input  logic             fft_valid_in,
  input  logic             fft_last_in,
  input  logic [MAG_W-1:0] fft_mag_in,
  output logic             peak_valid_out,
  output logic [31:0]      peak_bin_out,
  input  logic             det_ready_in,
  output logic [2:0]       frame_idx_out,
  output logic             busy_out,
  output logic             overrun_out
);

  localparam int               FRAME_SHIFT = $clog2(N_FRAMES);
  localparam logic [2:0]       LAST_FRAME  = 3'(N_FRAMES - 1);
  localparam logic [BIN_W-1:0] BIN_ONE     = BIN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SCAN,
    S_EMIT,
    S_WAIT_SLOT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        period_q;
  logic [31:0]        slot_cnt_q;
  logic [BIN_W-1:0]   bin_cnt_q;
  logic [MAG_W-1:0]   best_mag_q;
  logic [BIN_W-1:0]   best_bin_q;
  logic [2:0]         frame_idx_q;
  logic               overrun_q;

  logic               accept_start;
  logic               beat;
  logic               handshake;
  logic               slot_elapsed;
  logic [31:0]        period_raw;
  logic [31:0]        period_next;

  assign period_raw    = recording_length >> FRAME_SHIFT;
  assign period_next   = (period_raw == '0) ? 32'd1 : period_raw;
  assign slot_elapsed  = (slot_cnt_q >= period_q);
  assign frame_idx_out = frame_idx_q;
  assign overrun_out   = overrun_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    fft_start_out  = 1'b0;
    accept_start   = 1'b0;
    beat           = 1'b0;
    handshake      = 1'b0;
    peak_valid_out = 1'b0;
    peak_bin_out   = '0;
    busy_out       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          accept_start = 1'b1;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (fft_ready_in) begin
          fft_start_out = 1'b1;
          state_d       = S_SCAN;
        end
      end
      S_SCAN: begin
        beat = fft_valid_in;
        if (fft_valid_in && fft_last_in) state_d = S_EMIT;
      end
      S_EMIT: begin
        peak_valid_out                = 1'b1;
        peak_bin_out[BIN_W-1:0]       = best_bin_q;
        if (det_ready_in) begin
          handshake = 1'b1;
          state_d   = (frame_idx_q == LAST_FRAME) ? S_DONE : S_WAIT_SLOT;
        end
      end
      S_WAIT_SLOT: begin
        // An already-elapsed slot launches straight away instead of paying a LAUNCH cycle.
        if (slot_elapsed) begin
          if (fft_ready_in) begin
            fft_start_out = 1'b1;
            state_d       = S_SCAN;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      period_q    <= '0;
      slot_cnt_q  <= '0;
      bin_cnt_q   <= '0;
      best_mag_q  <= '0;
      best_bin_q  <= '0;
      frame_idx_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (accept_start) begin
        period_q    <= period_next;
        slot_cnt_q  <= '0;
        frame_idx_q <= '0;
        overrun_q   <= 1'b0;
      end else if (busy_out) begin
        // Loaded with 1 so the count equals cycles elapsed since the launch pulse.
        if (fft_start_out)      slot_cnt_q <= 32'd1;
        else if (!slot_elapsed) slot_cnt_q <= slot_cnt_q + 32'd1;
      end

      if ((state_q == S_SCAN || state_q == S_EMIT) && slot_elapsed)
        overrun_q <= 1'b1;

      if (fft_start_out) begin
        bin_cnt_q <= '0;
      end else if (beat) begin
        bin_cnt_q <= bin_cnt_q + BIN_ONE;
        if (bin_cnt_q != '0 && fft_mag_in > best_mag_q) begin
          best_mag_q <= fft_mag_in;
          best_bin_q <= bin_cnt_q;
        end
      end

      if (handshake) begin
        best_mag_q <= '0;
        best_bin_q <= '0;
        if (frame_idx_q != LAST_FRAME) frame_idx_q <= frame_idx_q + 3'd1;
      end
    end
  end

endmodule
